ff_array_port_ctrl: RTL and testbench
=====================================

Name: ff_array_port_ctrl

Overview:
- Initiator-side controller for the flop-based dual-address array (registered write port on addr0, registered read address on addr1, combinational dout0).
- Accepts independent valid/ready read and write requests and drives the array's csb0/web0/addr0/addr1/din0.
- Returns read data in order through a 2-entry response buffer, with same-cycle write-to-read forwarding.
- Sits between rename/ROB-side logic and any array instance (RAT checkpoints, free lists, small tables).

Parameters:
- S_INDEX, 4, array address width; the array has 2**S_INDEX entries.
- WIDTH, 32, data width.

Ports:
- clk  in  1  single clock, shared with the array.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  write request accepted when wr_valid && wr_ready.
- wr_addr  in  S_INDEX  write address.
- wr_data  in  WIDTH  write data.
- rd_valid  in  1  read request valid.
- rd_ready  out  1  read request accepted when rd_valid && rd_ready.
- rd_addr  in  S_INDEX  read address.
- rsp_valid  out  1  read response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  WIDTH  read response data.
- arr_csb0  out  1  array chip select, active low.
- arr_web0  out  1  array write enable, active low.
- arr_addr0  out  S_INDEX  array write address.
- arr_addr1  out  S_INDEX  array read address.
- arr_din0  out  WIDTH  array write data.
- arr_dout0  in  WIDTH  array read data.

Behaviour:
- Reset (rst=1 at a clk edge):
  - rsp_valid=0.
  - Response buffer and issue stage empty.
  - Array drive: arr_csb0=1, arr_web0=1.
  - Perf counters (if enabled) = 0.
  - Reset mid-operation discards all in-flight reads and the buffered responses. A write accepted in the cycle of reset is not guaranteed to land.
- Write path:
  - wr_ready=1 whenever not in reset.
  - An accepted write drives arr_csb0=0, arr_web0=0, arr_addr0=wr_addr, arr_din0=wr_data in the same cycle.
  - The array commits the write at the second edge after acceptance.
- Write-disable cycle:
  - The array holds its latched web0 while csb0=1.
  - The cycle after any write cycle with no new write, the block drives arr_csb0=0, arr_web0=1 for exactly one cycle, even when there is no read.
  - arr_csb0=1 only when there is no request and the previous cycle was not a write.
- Read path:
  - An accepted read drives arr_csb0=0, arr_addr1=rd_addr, arr_web0=1 unless a write is accepted in the same cycle.
  - Issue-stage flag s1_valid is set at that edge.
  - In the following cycle, arr_dout0 is captured into the response buffer unconditionally.
  - Read latency is 1 cycle: rsp_valid rises the second edge after acceptance when the buffer is empty.
- Read ordering:
  - A read issued one cycle after a write to the same address sees the new data with no forwarding, because the write commits at the same edge the read address latches.
  - Same-cycle read and write to the same address: the array returns old data. The block records fwd=1 and fwd_data=wr_data in the issue stage and substitutes fwd_data at capture. The read therefore returns the newly written value.
- Response buffer:
  - 2-entry FIFO with pointer wrap at 2.
  - rsp_valid = buffer not empty; head pops on rsp_valid && rsp_ready.
- Credits:
  - occ = s1_valid + buffer count.
  - rd_ready = (occ < 2) || (rsp_valid && rsp_ready).
  - The buffer therefore never overflows; rsp_valid is held stable with stable rsp_data under backpressure.
- Simultaneous events:
  - Push and pop in the same cycle keep the count unchanged.
  - A push into an empty buffer is visible the next cycle; there is no combinational bypass.
- Both reads and writes accepted every cycle give full throughput of 1 read and 1 write per cycle.

Optional Feature:
- Macro: FF_ARRAY_CTRL_PERF_EN.
- Defined: adds outputs perf_rd_cnt, perf_wr_cnt and perf_fwd_cnt, each 32 bits.
  - They count accepted reads, accepted writes and forwarded reads.
  - They saturate at 32'hFFFF_FFFF and are cleared by rst.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Write addr 3 = 32'hDEAD_BEEF; idle 1 cycle; read addr 3 -> rsp_valid 2 edges after read accept, rsp_data=32'hDEAD_BEEF. The idle cycle shows arr_csb0=0, arr_web0=1.
- Same cycle: write addr 5 = 32'h1234 and read addr 5 (old value 0) -> rsp_data=32'h1234. perf_fwd_cnt=1 when enabled.
- Write addr 7 = 32'hA5; next cycle read addr 7 -> rsp_data=32'hA5.
- Hold rsp_ready=0 and issue reads to addrs 1,2,3 -> rd_ready drops after 2 accepts. rsp_data stays the addr-1 value. Release rsp_ready -> responses arrive in order 1,2, then the third read is accepted and returned.
- Back-to-back reads and writes every cycle for 64 cycles to random addresses -> scoreboard matches every response; no rd_ready drop with rsp_ready=1.
- Assert rst with 2 responses buffered -> next cycle rsp_valid=0, arr_csb0=1, arr_web0=1, rd_ready=1.

Source files
------------

// File: rtl/ff_array_port_if.sv
// rtl/ff_array_port_if.sv - request/response bundle between an array client and ff_array_port_ctrl
//
// Purpose: carries the write-request, read-request and read-response handshakes.
// Modports:
//   master - client side: drives requests and rsp_ready; sees ready flags and responses.
//   slave  - controller side: the opposite directions.
// Signals:
//   wr_valid/wr_ready/wr_addr/wr_data  write request
//   rd_valid/rd_ready/rd_addr          read request
//   rsp_valid/rsp_ready/rsp_data       in-order read response
interface ff_array_port_if #(
    parameter int S_INDEX = 4,
    parameter int WIDTH   = 32
) ();
    logic               wr_valid;
    logic               wr_ready;
    logic [S_INDEX-1:0] wr_addr;
    logic [WIDTH-1:0]   wr_data;
    logic               rd_valid;
    logic               rd_ready;
    logic [S_INDEX-1:0] rd_addr;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [WIDTH-1:0]   rsp_data;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rsp_ready,
        input  wr_ready, rd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rsp_ready,
        output wr_ready, rd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/ff_array_port_ctrl.sv
// rtl/ff_array_port_ctrl.sv - initiator-side controller for the flop-based dual-address array
//
// Purpose: accepts independent read/write requests, drives the array's write port
// (addr0/din0, latched by the array) and read address (addr1, latched by the array),
// and returns read data in order through a 2-entry response buffer. A read and a
// write to the same address in the same cycle return the newly written data.
// Ports:
//   clk, rst         single clock, synchronous active-high reset
//   port (slave)     write request, read request, read response handshakes
//   arr_csb0         array chip select, active low
//   arr_web0         array write enable, active low
//   arr_addr0        array write address
//   arr_addr1        array read address
//   arr_din0         array write data
//   arr_dout0        array read data (combinational from the latched addr1)
//   perf_*_cnt       saturating counters of accepted reads, writes and forwarded reads,
//                    present only when FF_ARRAY_CTRL_PERF_EN is defined
module ff_array_port_ctrl #(
    parameter int S_INDEX = 4,
    parameter int WIDTH   = 32
) (
    input  logic               clk,
    input  logic               rst,
    ff_array_port_if.slave     port,
    output logic               arr_csb0,
    output logic               arr_web0,
    output logic [S_INDEX-1:0] arr_addr0,
    output logic [S_INDEX-1:0] arr_addr1,
    output logic [WIDTH-1:0]   arr_din0,
    input  logic [WIDTH-1:0]   arr_dout0
`ifdef FF_ARRAY_CTRL_PERF_EN
    ,
    output logic [31:0]        perf_rd_cnt,
    output logic [31:0]        perf_wr_cnt,
    output logic [31:0]        perf_fwd_cnt
`endif
);

    // Handshake events
    logic wr_fire;
    logic rd_fire;
    logic pop;
    logic push;

    // Issue stage: a read whose address the array latched at the last edge
    logic             s1_valid_q, s1_valid_d;
    logic             fwd_q, fwd_d;
    logic [WIDTH-1:0] fwd_data_q, fwd_data_d;

    // Previous cycle carried a write; the array keeps web0 latched low until it
    // sees a selected cycle with web0=1
    logic prev_wr_q, prev_wr_d;

    // Response buffer
    logic [WIDTH-1:0] buf_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic [1:0]       occ;
    logic [WIDTH-1:0] capture_data;

    assign pop  = port.rsp_valid && port.rsp_ready;
    assign push = s1_valid_q;

    // A read in flight still needs a buffer slot, so it counts against credit
    assign occ = count_q + {1'b0, s1_valid_q};

    assign port.wr_ready  = !rst;
    assign port.rd_ready  = !rst && ((occ < 2'd2) || pop);
    assign port.rsp_valid = (count_q != 2'd0);
    assign port.rsp_data  = buf_q[rd_ptr_q];

    assign wr_fire = port.wr_valid && port.wr_ready;
    assign rd_fire = port.rd_valid && port.rd_ready;

    // Array drive. The cycle after a write is kept selected with web0 high so the
    // array's latched write enable is cleared even when no read is issued.
    assign arr_csb0  = rst ? 1'b1 : !(wr_fire || rd_fire || prev_wr_q);
    assign arr_web0  = !wr_fire;
    assign arr_addr0 = port.wr_addr;
    assign arr_din0  = port.wr_data;
    assign arr_addr1 = port.rd_addr;

    // The array returns pre-write data for a same-cycle same-address read, so the
    // write data is carried alongside the read and substituted at capture.
    assign capture_data = fwd_q ? fwd_data_q : arr_dout0;

    always_comb begin
        s1_valid_d = rd_fire;
        fwd_d      = wr_fire && rd_fire && (port.wr_addr == port.rd_addr);
        fwd_data_d = port.wr_data;
        prev_wr_d  = wr_fire;
        wr_ptr_d   = push ? !wr_ptr_q : wr_ptr_q;
        rd_ptr_d   = pop ? !rd_ptr_q : rd_ptr_q;
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            fwd_q      <= 1'b0;
            prev_wr_q  <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            fwd_q      <= fwd_d;
            prev_wr_q  <= prev_wr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Data storage needs no reset; validity is tracked by the flags above
    always_ff @(posedge clk) begin
        fwd_data_q <= fwd_data_d;
        if (push && !rst) begin
            buf_q[wr_ptr_q] <= capture_data;
        end
    end

`ifdef FF_ARRAY_CTRL_PERF_EN
    logic [31:0] perf_rd_q, perf_rd_d;
    logic [31:0] perf_wr_q, perf_wr_d;
    logic [31:0] perf_fwd_q, perf_fwd_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    always_comb begin
        perf_rd_d  = sat_inc(perf_rd_q, rd_fire);
        perf_wr_d  = sat_inc(perf_wr_q, wr_fire);
        perf_fwd_d = sat_inc(perf_fwd_q, fwd_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_rd_q  <= 32'd0;
            perf_wr_q  <= 32'd0;
            perf_fwd_q <= 32'd0;
        end else begin
            perf_rd_q  <= perf_rd_d;
            perf_wr_q  <= perf_wr_d;
            perf_fwd_q <= perf_fwd_d;
        end
    end

    assign perf_rd_cnt  = perf_rd_q;
    assign perf_wr_cnt  = perf_wr_q;
    assign perf_fwd_cnt = perf_fwd_q;
`endif

endmodule

// File: tb/tb_ff_array_port_ctrl.sv
// tb/tb_ff_array_port_ctrl.sv - self-checking bench for ff_array_port_ctrl with a flop-array model
module tb_ff_array_port_ctrl;
    localparam int S_INDEX = 4;
    localparam int WIDTH   = 32;
    localparam int DEPTH   = 2 ** S_INDEX;

    logic               clk;
    logic               rst;
    logic               arr_csb0;
    logic               arr_web0;
    logic [S_INDEX-1:0] arr_addr0;
    logic [S_INDEX-1:0] arr_addr1;
    logic [WIDTH-1:0]   arr_din0;
    logic [WIDTH-1:0]   arr_dout0;
`ifdef FF_ARRAY_CTRL_PERF_EN
    logic [31:0]        perf_rd_cnt;
    logic [31:0]        perf_wr_cnt;
    logic [31:0]        perf_fwd_cnt;
`endif

    ff_array_port_if #(.S_INDEX(S_INDEX), .WIDTH(WIDTH)) bus ();

    ff_array_port_ctrl #(.S_INDEX(S_INDEX), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .port      (bus),
        .arr_csb0  (arr_csb0),
        .arr_web0  (arr_web0),
        .arr_addr0 (arr_addr0),
        .arr_addr1 (arr_addr1),
        .arr_din0  (arr_din0),
        .arr_dout0 (arr_dout0)
`ifdef FF_ARRAY_CTRL_PERF_EN
        ,
        .perf_rd_cnt  (perf_rd_cnt),
        .perf_wr_cnt  (perf_wr_cnt),
        .perf_fwd_cnt (perf_fwd_cnt)
`endif
    );

    // Flop-based array: inputs latch on selected cycles, write commits one edge later
    logic [WIDTH-1:0]   mem [DEPTH] = '{default: '0};
    logic               a_web0_q = 1'b1;
    logic [S_INDEX-1:0] a_addr0_q = '0;
    logic [S_INDEX-1:0] a_addr1_q = '0;
    logic [WIDTH-1:0]   a_din0_q = '0;

    always @(posedge clk) begin
        if (!a_web0_q) mem[a_addr0_q] <= a_din0_q;
        if (!arr_csb0) begin
            a_web0_q  <= arr_web0;
            a_addr0_q <= arr_addr0;
            a_din0_q  <= arr_din0;
            a_addr1_q <= arr_addr1;
        end
    end
    assign arr_dout0 = mem[a_addr1_q];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference: a write is visible to any read accepted in the same cycle or later
    logic [WIDTH-1:0] ref_mem [DEPTH];
    logic [WIDTH-1:0] exp_q [$];
    int tests = 0;
    int fails = 0;
    int n_rd = 0;
    int n_wr = 0;
    int n_fwd = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic wf, rf, pf;
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
        end else begin
            wf = bus.wr_valid && bus.wr_ready;
            rf = bus.rd_valid && bus.rd_ready;
            pf = bus.rsp_valid && bus.rsp_ready;
            if (pf) begin
                if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
                else chk("rsp_data_order", bus.rsp_data, exp_q.pop_front());
            end
            if (wf) begin
                ref_mem[bus.wr_addr] = bus.wr_data;
                n_wr++;
            end
            if (rf) begin
                exp_q.push_back(ref_mem[bus.rd_addr]);
                n_rd++;
                if (wf && bus.wr_addr == bus.rd_addr) n_fwd++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.wr_valid  = 1'b0;
        bus.rd_valid  = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 20 && (exp_q.size() != 0 || bus.rsp_valid); i++) tick();
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic chk_perf(input string tag);
`ifdef FF_ARRAY_CTRL_PERF_EN
        chk({tag, "_perf_rd"}, perf_rd_cnt, 32'(n_rd));
        chk({tag, "_perf_wr"}, perf_wr_cnt, 32'(n_wr));
        chk({tag, "_perf_fwd"}, perf_fwd_cnt, 32'(n_fwd));
`else
        chk({tag, "_arr_idle_csb0"}, 32'(arr_csb0), 32'd1);
`endif
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        rst = 1'b1;
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_valid = 1'b0; bus.rd_addr = '0; bus.rsp_ready = 1'b1;
        tick();
        tick();
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_csb0", 32'(arr_csb0), 32'd1);
        chk("reset_web0", 32'(arr_web0), 32'd1);
        rst = 1'b0;
        #1;
        chk("post_reset_wr_ready", 32'(bus.wr_ready), 32'd1);
        chk("post_reset_rd_ready", 32'(bus.rd_ready), 32'd1);
        chk("post_reset_csb0", 32'(arr_csb0), 32'd1);

        // Write, idle, read back
        bus.wr_valid = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 32'hDEAD_BEEF;
        #1;
        chk("wr_csb0", 32'(arr_csb0), 32'd0);
        chk("wr_web0", 32'(arr_web0), 32'd0);
        chk("wr_addr0", 32'(arr_addr0), 32'd3);
        chk("wr_din0", arr_din0, 32'hDEAD_BEEF);
        tick();
        bus.wr_valid = 1'b0;
        #1;
        chk("wdis_csb0", 32'(arr_csb0), 32'd0);
        chk("wdis_web0", 32'(arr_web0), 32'd1);
        tick();
        bus.rd_valid = 1'b1; bus.rd_addr = 4'd3;
        #1;
        chk("rd_csb0", 32'(arr_csb0), 32'd0);
        chk("rd_web0", 32'(arr_web0), 32'd1);
        chk("rd_addr1", 32'(arr_addr1), 32'd3);
        tick();
        bus.rd_valid = 1'b0;
        #1;
        chk("rd_lat_edge1_valid", 32'(bus.rsp_valid), 32'd0);
        chk("idle_csb0", 32'(arr_csb0), 32'd1);
        tick();
        chk("rd_lat_edge2_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rd_data_3", bus.rsp_data, 32'hDEAD_BEEF);
        drain();

        // Same-cycle write and read to one address
        bus.wr_valid = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 32'h1234;
        bus.rd_valid = 1'b1; bus.rd_addr = 4'd5;
        tick();
        bus.wr_valid = 1'b0; bus.rd_valid = 1'b0;
        tick();
        chk("fwd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("fwd_rsp_data", bus.rsp_data, 32'h1234);
        drain();
        chk_perf("fwd");

        // Write then read next cycle
        bus.wr_valid = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 32'hA5;
        tick();
        bus.wr_valid = 1'b0; bus.rd_valid = 1'b1; bus.rd_addr = 4'd7;
        tick();
        bus.rd_valid = 1'b0;
        tick();
        chk("raw_next_data", bus.rsp_data, 32'hA5);
        drain();

        // Backpressure with three reads
        bus.wr_valid = 1'b1; bus.wr_addr = 4'd1; bus.wr_data = 32'h111;
        tick();
        bus.wr_addr = 4'd2; bus.wr_data = 32'h222;
        tick();
        bus.wr_valid = 1'b0;
        tick();
        bus.rsp_ready = 1'b0;
        bus.rd_valid = 1'b1; bus.rd_addr = 4'd1;
        #1;
        chk("bp_rd_ready_1", 32'(bus.rd_ready), 32'd1);
        tick();
        bus.rd_addr = 4'd2;
        #1;
        chk("bp_rd_ready_2", 32'(bus.rd_ready), 32'd1);
        tick();
        bus.rd_addr = 4'd3;
        #1;
        chk("bp_rd_ready_drop", 32'(bus.rd_ready), 32'd0);
        tick();
        chk("bp_rd_ready_held", 32'(bus.rd_ready), 32'd0);
        chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("bp_rsp_data", bus.rsp_data, 32'h111);
        tick();
        chk("bp_rsp_data_stable", bus.rsp_data, 32'h111);
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_release_rd_ready", 32'(bus.rd_ready), 32'd1);
        tick();
        drain();

        // Full throughput: read and write every cycle
        for (int i = 0; i < 64; i++) begin
            bus.wr_valid = 1'b1; bus.rd_valid = 1'b1; bus.rsp_ready = 1'b1;
            bus.wr_addr = 4'($urandom_range(0, 7));
            bus.wr_data = $urandom;
            bus.rd_addr = 4'($urandom_range(0, 7));
            #1;
            chk("tput_rd_ready", 32'(bus.rd_ready), 32'd1);
            chk("tput_wr_ready", 32'(bus.wr_ready), 32'd1);
            tick();
        end
        drain();
        chk_perf("tput");

        // Random valids and backpressure
        for (int i = 0; i < 96; i++) begin
            bus.wr_valid  = 1'($urandom_range(0, 1));
            bus.rd_valid  = 1'($urandom_range(0, 1));
            bus.rsp_ready = 1'($urandom_range(0, 1));
            bus.wr_addr   = 4'($urandom_range(0, 15));
            bus.wr_data   = $urandom;
            bus.rd_addr   = 4'($urandom_range(0, 15));
            tick();
        end
        drain();
        chk_perf("mixed");

        // Reset with two responses buffered
        bus.rsp_ready = 1'b0;
        bus.rd_valid = 1'b1; bus.rd_addr = 4'd0;
        tick();
        bus.rd_addr = 4'd1;
        tick();
        bus.rd_valid = 1'b0;
        tick();
        chk("pre_rst_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_mid_csb0", 32'(arr_csb0), 32'd1);
        chk("rst_mid_web0", 32'(arr_web0), 32'd1);
        chk("rst_mid_rd_ready", 32'(bus.rd_ready), 32'd1);
`ifdef FF_ARRAY_CTRL_PERF_EN
        chk("rst_perf_rd", perf_rd_cnt, 32'd0);
        chk("rst_perf_fwd", perf_fwd_cnt, 32'd0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
